pe: RTL and testbench
=====================

Name: pe

Overview:
- Weight-stationary systolic tile of ROWS x COLS multiply-accumulate cells with double-buffered weights.
- Activations enter on the left, shift one column right per cycle, and exit on the right.
- Partial sums enter at the top, gain one product per row, and exit at the bottom.
- Weights shift down through a shadow bank while the other bank computes; the tile sits in a larger systolic array and chains to neighbouring tiles on all four edges.

Parameters:
ROWS, 8, number of cell rows (activation lanes)
COLS, 8, number of cell columns (sum/weight lanes)
DW, 16, data width of activations, weights and sums

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
EN  input  1  global enable; 0 freezes every register
SELECTOR  input  1  bank select; 1 = bank0 loads and bank1 computes, 0 = bank1 loads and bank0 computes
W_EN  input  1  weight shift enable for the loading bank (qualified by EN)
active_left  input  ROWS*DW  activation per row, lane r at bits [r*DW +: DW]
active_right  output  ROWS*DW  registered activation leaving column COLS-1, per row
in_sum  input  COLS*DW  partial sum entering row 0, per column
out_sum  output  COLS*DW  registered partial sum leaving row ROWS-1, per column
in_weight_above  input  COLS*DW  weight entering loading bank of row 0, per column
out_weight_below  output  COLS*DW  loading-bank weight of row ROWS-1, per column

Behaviour:
- Clock and reset: one clock domain (clk); reset asynchronous, active-high.
- Per-cell state:
  - a[r][c]: activation register
  - s[r][c]: sum register
  - w0[r][c], w1[r][c]: weight banks
- Reset: all registers are 0, so every output reads 0 while reset is high and on release. Reset mid-operation discards all data immediately.
- EN=0: no register changes, regardless of SELECTOR or W_EN.
- Activation path (EN=1):
  - ain[r][c] = active_left[r] for c=0, else a[r][c-1].
  - a[r][c] <= ain[r][c].
  - active_right[r] = a[r][COLS-1]; latency COLS cycles.
- Sum path (EN=1):
  - sin[r][c] = in_sum[c] for r=0, else s[r-1][c].
  - s[r][c] <= sin[r][c] + ain[r][c]*wuse[r][c].
  - wuse = w1 when SELECTOR=1, w0 when SELECTOR=0.
  - out_sum[c] = s[ROWS-1][c].
- Arithmetic: product and sum keep the low DW bits (modulo 2^DW wrap, identical for signed and unsigned). No saturation, no overflow flag.
- Weight load (EN=1 and W_EN=1):
  - The loading bank (w0 when SELECTOR=1, w1 when SELECTOR=0) shifts down: row 0 takes in_weight_above[c], row r takes row r-1.
  - The compute bank is never written.
  - W_EN=0 holds the loading bank.
  - out_weight_below[c] = loading bank of row ROWS-1, so it switches banks combinationally with SELECTOR.
- Filling: loading a full bank takes ROWS enabled W_EN cycles. Weights presented on cycle k end up in row ROWS-1-k.
- Bank swap: toggling SELECTOR takes effect on the same edge.
  - Products use the new compute bank from that edge.
  - Loading continues into the other bank from that edge.
  - Load and compute in the same cycle is legal.
- Steady state: with constant inputs, outputs are stable after ROWS+COLS enabled cycles.
- Input skew and output de-skew are the user's responsibility.

Test Plan:
- Reset: hold reset 2 cycles with nonzero inputs -> active_right, out_sum and out_weight_below all 0. Assert reset mid-stream -> all outputs 0 on the same cycle, no clock edge required.
- Load then compute:
  - SELECTOR=1, W_EN=1, in_weight_above lanes all 1, for 8 cycles; then SELECTOR=0, W_EN=0.
  - active_left lanes all 6, in_sum 0.
  - After 16 cycles -> every out_sum lane = 48 (8 rows x 6 x 1); active_right lanes = 6.
- Double-buffered reload:
  - While computing on bank0 (SELECTOR=0), load all-2 weights into bank1 for 8 cycles -> out_sum stays 48.
  - Then set SELECTOR=1 and active_left = 7 -> after 16 cycles out_sum = 112.
- Sum chaining: weights 1, activations 6, in_sum lanes = 100 -> out_sum = 148.
- Wrap: activation 0x4000, weights 4 -> product 0x10000 truncates to 0, so out_sum = in_sum. Activation 0xFFFF, weight 1, 8 rows, in_sum 0 -> out_sum = 0xFFF8.
- Enable: drop EN for 5 cycles mid-stream while changing all inputs -> outputs unchanged. Raise EN -> pipeline resumes from the frozen state; out_weight_below shifts only with W_EN=1.

Source files
------------

// File: rtl/pe.sv
// Weight-stationary ROWS x COLS systolic MAC tile with double-buffered weight banks.
// Activations flow right, partial sums flow down, weights shift down the loading bank.
module pe #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    parameter int unsigned DW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EN,
    input  logic                 SELECTOR,
    input  logic                 W_EN,
    input  logic [ROWS*DW-1:0]   active_left,
    output logic [ROWS*DW-1:0]   active_right,
    input  logic [COLS*DW-1:0]   in_sum,
    output logic [COLS*DW-1:0]   out_sum,
    input  logic [COLS*DW-1:0]   in_weight_above,
    output logic [COLS*DW-1:0]   out_weight_below
);

    // Per-cell state
    logic [DW-1:0] a  [ROWS][COLS];
    logic [DW-1:0] s  [ROWS][COLS];
    logic [DW-1:0] w0 [ROWS][COLS];
    logic [DW-1:0] w1 [ROWS][COLS];

    // Per-cell combinational inputs
    logic [DW-1:0] ain   [ROWS][COLS];
    logic [DW-1:0] sin   [ROWS][COLS];
    logic [DW-1:0] wuse  [ROWS][COLS];
    logic [DW-1:0] wl_in [ROWS][COLS];
    logic [DW-1:0] s_nxt [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_left
                assign ain[r][c] = active_left[r*DW +: DW];
            end else begin : g_inner
                assign ain[r][c] = a[r][c-1];
            end

            // Row 0 is fed from the tile edge; other rows chain from the row above.
            if (r == 0) begin : g_top
                assign sin[r][c]   = in_sum[c*DW +: DW];
                assign wl_in[r][c] = in_weight_above[c*DW +: DW];
            end else begin : g_below
                assign sin[r][c]   = s[r-1][c];
                assign wl_in[r][c] = SELECTOR ? w0[r-1][c] : w1[r-1][c];
            end

            assign wuse[r][c]  = SELECTOR ? w1[r][c] : w0[r][c];
            assign s_nxt[r][c] = sin[r][c] + ain[r][c] * wuse[r][c];
        end
    end

    // All cell registers; modulo-2^DW arithmetic falls out of the DW-bit widths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a[r][c]  <= '0;
                    s[r][c]  <= '0;
                    w0[r][c] <= '0;
                    w1[r][c] <= '0;
                end
            end
        end else if (EN) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a[r][c] <= ain[r][c];
                    s[r][c] <= s_nxt[r][c];
                    if (W_EN) begin
                        if (SELECTOR) begin
                            w0[r][c] <= wl_in[r][c];
                        end else begin
                            w1[r][c] <= wl_in[r][c];
                        end
                    end
                end
            end
        end
    end

    // Edge outputs; the weight output follows SELECTOR without a clock edge.
    always_comb begin
        active_right     = '0;
        out_sum          = '0;
        out_weight_below = '0;
        for (int r = 0; r < ROWS; r++) begin
            active_right[r*DW +: DW] = a[r][COLS-1];
        end
        for (int c = 0; c < COLS; c++) begin
            out_sum[c*DW +: DW]          = s[ROWS-1][c];
            out_weight_below[c*DW +: DW] = SELECTOR ? w0[ROWS-1][c] : w1[ROWS-1][c];
        end
    end

endmodule

// File: tb/tb_pe.sv
// Directed bench for the pe systolic tile: reset, load/compute, bank swap, chaining, wrap, enable.
module tb_pe;
    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned BW   = ROWS * DW;

    logic              clk = 1'b0;
    logic              reset;
    logic              EN;
    logic              SELECTOR;
    logic              W_EN;
    logic [BW-1:0]     active_left;
    logic [BW-1:0]     active_right;
    logic [BW-1:0]     in_sum;
    logic [BW-1:0]     out_sum;
    logic [BW-1:0]     in_weight_above;
    logic [BW-1:0]     out_weight_below;

    int checks = 0;
    int errors = 0;

    pe #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .EN               (EN),
        .SELECTOR         (SELECTOR),
        .W_EN             (W_EN),
        .active_left      (active_left),
        .active_right     (active_right),
        .in_sum           (in_sum),
        .out_sum          (out_sum),
        .in_weight_above  (in_weight_above),
        .out_weight_below (out_weight_below)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rep(input logic [DW-1:0] v);
        logic [BW-1:0] x;
        for (int i = 0; i < ROWS; i++) x[i*DW +: DW] = v;
        return x;
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] exp_v;
    logic [BW-1:0] lane_v;

    initial begin
        // Reset with nonzero inputs
        reset = 1'b1; EN = 1'b1; SELECTOR = 1'b1; W_EN = 1'b1;
        active_left = rep(16'd3); in_sum = rep(16'd5); in_weight_above = rep(16'd7);
        step(2);
        check("rst_act",  active_right,     '0);
        check("rst_sum",  out_sum,          '0);
        check("rst_wgt",  out_weight_below, '0);
        reset = 1'b0;
        #1;
        check("rel_sum",  out_sum,          '0);

        // Fill bank0 with ones; row ROWS-1 only sees the first weight on the ROWS-th edge
        SELECTOR = 1'b1; W_EN = 1'b1; in_weight_above = rep(16'd1);
        active_left = '0; in_sum = '0;
        step(7);
        check("fill7_wgt", out_weight_below, '0);
        step(1);
        check("fill8_wgt", out_weight_below, rep(16'd1));

        // Compute on bank0
        SELECTOR = 1'b0; W_EN = 1'b0; active_left = rep(16'd6); in_sum = '0;
        step(16);
        check("sum48", out_sum, rep(16'd48));
        check("act6",  active_right, rep(16'd6));

        // Reload bank1 with twos while bank0 computes
        W_EN = 1'b1; in_weight_above = rep(16'd2);
        step(8);
        check("reload_sum", out_sum, rep(16'd48));
        check("reload_wgt", out_weight_below, rep(16'd2));

        // Swap to bank1
        W_EN = 1'b0; SELECTOR = 1'b1; active_left = rep(16'd7);
        step(16);
        check("sum112", out_sum, rep(16'd112));

        // Sum chaining on bank0
        SELECTOR = 1'b0; active_left = rep(16'd6); in_sum = rep(16'd100);
        step(16);
        check("sum148", out_sum, rep(16'd148));

        // Freeze with all data inputs changing
        EN = 1'b0; W_EN = 1'b1; active_left = '0; in_sum = '0; in_weight_above = rep(16'd9);
        step(5);
        check("frz_sum", out_sum, rep(16'd148));
        check("frz_act", active_right, rep(16'd6));
        check("frz_wgt", out_weight_below, rep(16'd2));
        SELECTOR = 1'b1;
        #1;
        check("frz_selmux", out_weight_below, rep(16'd1));
        SELECTOR = 1'b0;
        #1;

        // Resume from frozen state
        active_left = rep(16'd6); in_sum = rep(16'd100); W_EN = 1'b0; EN = 1'b1;
        step(3);
        check("res_sum", out_sum, rep(16'd148));
        check("res_hold_wgt", out_weight_below, rep(16'd2));
        W_EN = 1'b1;
        step(7);
        check("res_w7", out_weight_below, rep(16'd2));
        step(1);
        check("res_w8", out_weight_below, rep(16'd9));
        check("res_sum2", out_sum, rep(16'd148));

        // Wrap: 0x4000 * 4 truncates to 0
        in_weight_above = rep(16'd4);
        step(8);
        W_EN = 1'b0; SELECTOR = 1'b1; active_left = rep(16'h4000); in_sum = rep(16'd5);
        step(16);
        check("wrap_prod", out_sum, rep(16'd5));
        check("wrap_act",  active_right, rep(16'h4000));

        // Wrap: 8 * 0xFFFF accumulates to 0xFFF8
        SELECTOR = 1'b0; active_left = rep(16'hFFFF); in_sum = '0;
        step(16);
        check("wrap_sum", out_sum, rep(16'hFFF8));

        // Distinct lanes: act r+1, in_sum 10c, bank1 weight c+1 loaded during compute
        for (int i = 0; i < ROWS; i++) active_left[i*DW +: DW] = DW'(i + 1);
        for (int i = 0; i < COLS; i++) in_sum[i*DW +: DW] = DW'(10 * i);
        for (int i = 0; i < COLS; i++) in_weight_above[i*DW +: DW] = DW'(i + 1);
        W_EN = 1'b1;
        step(8);
        W_EN = 1'b0;
        step(8);
        for (int i = 0; i < COLS; i++) exp_v[i*DW +: DW] = DW'(10 * i + 36);
        check("lane_sum_b0", out_sum, exp_v);
        for (int i = 0; i < ROWS; i++) lane_v[i*DW +: DW] = DW'(i + 1);
        check("lane_act", active_right, lane_v);
        SELECTOR = 1'b1;
        step(16);
        for (int i = 0; i < COLS; i++) exp_v[i*DW +: DW] = DW'(10 * i + 36 * (i + 1));
        check("lane_sum_b1", out_sum, exp_v);

        // Mid-stream asynchronous reset, checked before any clock edge
        reset = 1'b1;
        #1;
        check("async_act", active_right,     '0);
        check("async_sum", out_sum,          '0);
        check("async_wgt", out_weight_below, '0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
